// File: rtl/sram_dbg_arb_pkg.sv
// Shared types and address map for the SRAM / debug-module arbiter.
package sram_dbg_arb_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = 4;

    localparam logic [AddrW-1:0] MemStartDef = 32'h0000_0000;
    localparam logic [AddrW-1:0] MemMaskDef  = 32'h0000_FFFF;
    localparam logic [AddrW-1:0] DbgStartDef = 32'h1000_0000;
    localparam logic [AddrW-1:0] DbgMaskDef  = 32'h0000_0FFF;

    typedef enum logic {
        HOST_INSTR = 1'b0,
        HOST_DATA  = 1'b1
    } host_e;

    typedef enum logic [1:0] {
        DEV_NONE = 2'd0,
        DEV_RAM  = 2'd1,
        DEV_DBG  = 2'd2
    } dev_e;

    typedef struct packed {
        logic  valid;
        host_e host;
        dev_e  dev;
    } pend_t;

endpackage

// File: rtl/sram_dbg_addr_decode.sv
// Maps an address onto the SRAM window, the debug-module window, or nothing.
module sram_dbg_addr_decode
    import sram_dbg_arb_pkg::*;
#(
    parameter logic [AddrW-1:0] MemStart = MemStartDef,
    parameter logic [AddrW-1:0] MemMask  = MemMaskDef,
    parameter logic [AddrW-1:0] DbgStart = DbgStartDef,
    parameter logic [AddrW-1:0] DbgMask  = DbgMaskDef
) (
    input  logic [AddrW-1:0] addr,
    output dev_e             dev
);

    // SRAM takes priority if the windows were ever configured to overlap
    always_comb begin
        dev = DEV_NONE;
        if ((addr & ~MemMask) == MemStart) begin
            dev = DEV_RAM;
        end else if ((addr & ~DbgMask) == DbgStart) begin
            dev = DEV_DBG;
        end
    end

endmodule

// File: rtl/sram_dbg_arbiter.sv
// Round-robin share of one SRAM and the debug-module window between the Ibex
// instruction and data ports, with single-outstanding response routing.
module sram_dbg_arbiter
    import sram_dbg_arb_pkg::*;
#(
    parameter logic [AddrW-1:0] MemStart = MemStartDef,
    parameter logic [AddrW-1:0] MemMask  = MemMaskDef,
    parameter logic [AddrW-1:0] DbgStart = DbgStartDef,
    parameter logic [AddrW-1:0] DbgMask  = DbgMaskDef
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,

    input  logic             instr_req_i,
    input  logic [AddrW-1:0] instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [DataW-1:0] instr_rdata_o,
    output logic             instr_err_o,

    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [BeW-1:0]   data_be_i,
    input  logic [AddrW-1:0] data_addr_i,
    input  logic [DataW-1:0] data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [DataW-1:0] data_rdata_o,
    output logic             data_err_o,

    output logic             ram_req_o,
    output logic             dbg_req_o,
    output logic             dev_we_o,
    output logic [BeW-1:0]   dev_be_o,
    output logic [AddrW-1:0] dev_addr_o,
    output logic [DataW-1:0] dev_wdata_o,

    input  logic             ram_rvalid_i,
    input  logic [DataW-1:0] ram_rdata_i,
    input  logic             dbg_rvalid_i,
    input  logic [DataW-1:0] dbg_rdata_i
);

    host_e            last_winner_q;
    pend_t            pend_q;
    logic             grant;
    host_e            winner;
    logic [AddrW-1:0] win_addr;
    dev_e             win_dev;
    logic [DataW-1:0] rsp_rdata;
    logic             rsp_err;
    logic             stray_rsp;

    // Round-robin pick; nothing is granted while reset is held
    always_comb begin
        grant  = 1'b0;
        winner = HOST_INSTR;
        if (rst_sys_n) begin
            if (instr_req_i && data_req_i) begin
                grant  = 1'b1;
                winner = (last_winner_q == HOST_DATA) ? HOST_INSTR : HOST_DATA;
            end else if (instr_req_i) begin
                grant  = 1'b1;
                winner = HOST_INSTR;
            end else if (data_req_i) begin
                grant  = 1'b1;
                winner = HOST_DATA;
            end
        end
    end

    assign instr_gnt_o = grant && (winner == HOST_INSTR);
    assign data_gnt_o  = grant && (winner == HOST_DATA);
    assign win_addr    = (winner == HOST_DATA) ? data_addr_i : instr_addr_i;

    sram_dbg_addr_decode #(
        .MemStart (MemStart),
        .MemMask  (MemMask),
        .DbgStart (DbgStart),
        .DbgMask  (DbgMask)
    ) u_addr_decode (
        .addr (win_addr),
        .dev  (win_dev)
    );

    // Shared device bus; the instruction port is always a full-word read
    always_comb begin
        ram_req_o   = 1'b0;
        dbg_req_o   = 1'b0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        if (grant) begin
            ram_req_o  = (win_dev == DEV_RAM);
            dbg_req_o  = (win_dev == DEV_DBG);
            dev_addr_o = win_addr;
            if (winner == HOST_DATA) begin
                dev_we_o    = data_we_i;
                dev_be_o    = data_be_i;
                dev_wdata_o = data_wdata_i;
            end else begin
                dev_be_o = '1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            last_winner_q <= HOST_DATA;
            pend_q.valid  <= 1'b0;
            pend_q.host   <= HOST_INSTR;
            pend_q.dev    <= DEV_NONE;
        end else begin
            pend_q.valid <= grant;
            if (grant) begin
                pend_q.host   <= winner;
                pend_q.dev    <= win_dev;
                last_winner_q <= winner;
            end
        end
    end

    // Only the device that was addressed may supply data; device rvalid is not needed
    // because latency is fixed, so stray responses simply never reach a host
    always_comb begin
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (pend_q.dev)
            DEV_RAM: rsp_rdata = ram_rdata_i;
            DEV_DBG: rsp_rdata = dbg_rdata_i;
            default: rsp_err   = 1'b1;
        endcase
    end

    always_comb begin
        instr_rvalid_o = pend_q.valid && (pend_q.host == HOST_INSTR);
        data_rvalid_o  = pend_q.valid && (pend_q.host == HOST_DATA);
        instr_rdata_o  = instr_rvalid_o ? rsp_rdata : '0;
        data_rdata_o   = data_rvalid_o  ? rsp_rdata : '0;
        instr_err_o    = instr_rvalid_o && rsp_err;
        data_err_o     = data_rvalid_o  && rsp_err;
    end

    assign stray_rsp = (ram_rvalid_i && !(pend_q.valid && (pend_q.dev == DEV_RAM))) ||
                       (dbg_rvalid_i && !(pend_q.valid && (pend_q.dev == DEV_DBG)));

    a_no_stray_rsp : assert property (@(posedge clk_sys) disable iff (!rst_sys_n) !stray_rsp)
        else $warning("sram_dbg_arbiter: unexpected device response dropped");

endmodule

// File: tb/tb_sram_dbg_arbiter.sv
// Directed and randomized bench for sram_dbg_arbiter against a transaction-level model.
module tb_sram_dbg_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        ram_req_o, dbg_req_o, dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o, dev_wdata_o;
    logic        ram_rvalid_i = 1'b0, dbg_rvalid_i = 1'b0;
    logic [31:0] ram_rdata_i = '0, dbg_rdata_i = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: who won last (0 instr, 1 data) and the single outstanding transaction
    bit m_last = 1'b1;
    bit m_pv   = 1'b0;
    bit m_ph   = 1'b0;
    int m_pd   = 0;

    // Bench-side device state and values captured at the last sample point
    bit          prev_ram = 1'b0, prev_dbg = 1'b0;
    logic        c_igt, c_dgt, c_irv, c_drv, c_ierr, c_derr, c_ram, c_dbg, c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr, c_wd, c_ird, c_drd, c_ramrd;
    bit          g_i, g_d;

    // Random-phase outstanding requests (a loser must hold its request)
    bit          ih = 1'b0, dh = 1'b0, dwe_h = 1'b0;
    logic [31:0] ia = '0, da = '0, dwd = '0;
    logic [3:0]  dbe_h = '0;
    bit          exp_i[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit          exp_irv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit          exp_drv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    sram_dbg_arbiter dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .ram_req_o      (ram_req_o),
        .dbg_req_o      (dbg_req_o),
        .dev_we_o       (dev_we_o),
        .dev_be_o       (dev_be_o),
        .dev_addr_o     (dev_addr_o),
        .dev_wdata_o    (dev_wdata_o),
        .ram_rvalid_i   (ram_rvalid_i),
        .ram_rdata_i    (ram_rdata_i),
        .dbg_rvalid_i   (dbg_rvalid_i),
        .dbg_rdata_i    (dbg_rdata_i)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Address map by plain range arithmetic: 0=none, 1=ram, 2=dbg
    function automatic int exp_dev(input logic [31:0] a);
        if (a < 32'h0001_0000) return 1;
        if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [5] = '{32'h0000_FFFF, 32'h0001_0000, 32'h1000_0FFF,
                                   32'h1000_1000, 32'h0FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return $urandom & 32'h0000_FFFC;
            1: return 32'h1000_0000 | ($urandom & 32'h0000_0FFC);
            2: return $urandom | 32'h2000_0000;
            default: return edges[$urandom_range(0, 4)];
        endcase
    endfunction

    // One cycle: drive just after the edge, check at the falling edge, advance model at the edge
    task automatic step(input bit rst, input bit ireq, input logic [31:0] iaddr,
                        input bit dreq, input bit dwe, input logic [3:0] dbe,
                        input logic [31:0] daddr, input logic [31:0] dwdata, input bit spur);
        bit          w_any, w_host, rv;
        int          w_dev;
        logic [31:0] w_addr, rd;
        rst_sys_n    = rst;
        instr_req_i  = ireq;  instr_addr_i = iaddr;
        data_req_i   = dreq;  data_we_i = dwe;  data_be_i = dbe;
        data_addr_i  = daddr; data_wdata_i = dwdata;
        ram_rvalid_i = prev_ram | spur;
        dbg_rvalid_i = prev_dbg;
        ram_rdata_i  = $urandom;
        dbg_rdata_i  = $urandom;
        @(negedge clk_sys);
        w_any  = rst && (ireq || dreq);
        w_host = (ireq && dreq) ? !m_last : dreq;
        w_addr = w_host ? daddr : iaddr;
        w_dev  = exp_dev(w_addr);
        rv     = rst && m_pv;
        rd     = (m_pd == 1) ? ram_rdata_i : (m_pd == 2) ? dbg_rdata_i : 32'h0;
        chk("instr_gnt",    32'(instr_gnt_o),    32'(w_any && !w_host));
        chk("data_gnt",     32'(data_gnt_o),     32'(w_any && w_host));
        chk("ram_req",      32'(ram_req_o),      32'(w_any && w_dev == 1));
        chk("dbg_req",      32'(dbg_req_o),      32'(w_any && w_dev == 2));
        chk("dev_we",       32'(dev_we_o),       32'(w_any && w_host && dwe));
        chk("dev_be",       32'(dev_be_o),       !w_any ? 32'h0 : w_host ? 32'(dbe) : 32'hF);
        chk("dev_addr",     dev_addr_o,          w_any ? w_addr : 32'h0);
        chk("dev_wdata",    dev_wdata_o,         (w_any && w_host) ? dwdata : 32'h0);
        chk("instr_rvalid", 32'(instr_rvalid_o), 32'(rv && !m_ph));
        chk("data_rvalid",  32'(data_rvalid_o),  32'(rv && m_ph));
        chk("instr_err",    32'(instr_err_o),    32'(rv && !m_ph && m_pd == 0));
        chk("data_err",     32'(data_err_o),     32'(rv && m_ph && m_pd == 0));
        chk("instr_rdata",  instr_rdata_o,       (rv && !m_ph) ? rd : 32'h0);
        chk("data_rdata",   data_rdata_o,        (rv && m_ph) ? rd : 32'h0);
        c_igt = instr_gnt_o;  c_dgt = data_gnt_o;  c_irv = instr_rvalid_o; c_drv = data_rvalid_o;
        c_ierr = instr_err_o; c_derr = data_err_o; c_ird = instr_rdata_o;  c_drd = data_rdata_o;
        c_ram = ram_req_o;    c_dbg = dbg_req_o;   c_we = dev_we_o;        c_be = dev_be_o;
        c_addr = dev_addr_o;  c_wd = dev_wdata_o;  c_ramrd = ram_rdata_i;
        g_i = w_any && !w_host;
        g_d = w_any && w_host;
        prev_ram = ram_req_o;
        prev_dbg = dbg_req_o;
        @(posedge clk_sys);
        if (!rst) begin
            m_pv = 1'b0; m_last = 1'b1;
        end else if (w_any) begin
            m_pv = 1'b1; m_ph = w_host; m_pd = w_dev; m_last = w_host;
        end else begin
            m_pv = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit spur);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, spur);
    endtask

    initial begin
        repeat (2) @(posedge clk_sys);
        #1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("reset gnt", 32'(c_igt | c_dgt), 32'h0);
        chk("reset dev_addr", c_addr, 32'h0);

        // First tie after reset goes to instr, then strict alternation
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
            chk("alt instr_gnt", 32'(c_igt), 32'(exp_i[k]));
            chk("alt data_gnt", 32'(c_dgt), 32'(!exp_i[k]));
            chk("alt addr", c_addr, exp_i[k] ? 32'h100 : 32'h200);
            chk("alt instr_rvalid", 32'(c_irv), 32'(exp_irv[k]));
            chk("alt data_rvalid", 32'(c_drv), 32'(exp_drv[k]));
        end
        idle(1'b0);
        chk("alt tail data_rvalid", 32'(c_drv), 32'h1);

        step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("fetch gnt", 32'(c_igt), 32'h1);
        chk("fetch ram_req", 32'(c_ram), 32'h1);
        chk("fetch be", 32'(c_be), 32'hF);
        idle(1'b0);
        chk("fetch rvalid", 32'(c_irv), 32'h1);
        chk("fetch rdata", c_ird, c_ramrd);
        chk("fetch err", 32'(c_ierr), 32'h0);

        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h1000_0004, 32'hA5A5_0001, 1'b0);
        chk("dbgwr gnt", 32'(c_dgt), 32'h1);
        chk("dbgwr dbg_req", 32'(c_dbg), 32'h1);
        chk("dbgwr ram_req", 32'(c_ram), 32'h0);
        chk("dbgwr we", 32'(c_we), 32'h1);
        chk("dbgwr be", 32'(c_be), 32'h3);
        chk("dbgwr wdata", c_wd, 32'hA5A5_0001);
        idle(1'b0);
        chk("dbgwr rvalid", 32'(c_drv), 32'h1);
        chk("dbgwr err", 32'(c_derr), 32'h0);

        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h0, 1'b0);
        chk("unmap gnt", 32'(c_dgt), 32'h1);
        chk("unmap dev req", 32'(c_ram | c_dbg), 32'h0);
        idle(1'b0);
        chk("unmap rvalid", 32'(c_drv), 32'h1);
        chk("unmap err", 32'(c_derr), 32'h1);
        chk("unmap rdata", c_drd, 32'h0);

        idle(1'b1);
        chk("spurious rvalid", 32'(c_irv | c_drv), 32'h0);

        step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        chk("prerst gnt", 32'(c_igt), 32'h1);
        step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
        chk("inrst gnt", 32'(c_igt | c_dgt), 32'h0);
        chk("inrst rvalid", 32'(c_irv | c_drv), 32'h0);
        chk("inrst ram_req", 32'(c_ram), 32'h0);
        step(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0);
        chk("postrst tie instr", 32'(c_igt), 32'h1);
        chk("postrst no rvalid", 32'(c_irv | c_drv), 32'h0);

        // Randomized traffic with held requests and occasional reset
        for (int n = 0; n < 600; n++) begin
            bit rst;
            if (!ih && $urandom_range(0, 3) != 0) begin
                ih = 1'b1; ia = rand_addr();
            end
            if (!dh && $urandom_range(0, 3) != 0) begin
                dh = 1'b1; da = rand_addr(); dwe_h = 1'($urandom);
                dbe_h = 4'($urandom); dwd = $urandom;
            end
            rst = ($urandom_range(0, 99) != 0);
            step(rst, ih, ia, dh, dwe_h, dbe_h, da, dwd, 1'b0);
            if (g_i) ih = 1'b0;
            if (g_d) dh = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
